hex_uart_tx: RTL and testbench



---
 rtl/hex_uart_tx.sv | 253 +++++++++++++++++++++++++
 tb/tb_hex_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_uart_tx.sv
// Debug UART that prints words as fixed-width uppercase hex plus CR LF; HEX_UART_PREFIX_EN adds a "0x" prefix.
// Latency: start bit 2 cycles after the FIFO goes non-empty. Backpressure: ready low when the FIFO is full, and overflow flags dropped words.

// Word FIFO. ready is registered and high when the FIFO is not full. A push while full is dropped.
module hex_uart_tx_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             empty,
   output logic             ready
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_nxt;
   logic             do_push;
   logic             do_pop;

   // Gate on the registered ready, so a pop cannot free a slot for a push in the same cycle.
   assign do_push  = push && ready;
   assign do_pop   = pop && !empty;
   assign empty    = (count == '0);
   assign head_dat = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop) begin
         count_nxt = count + 1'b1;
      end else if (!do_push && do_pop) begin
         count_nxt = count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ready  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         ready <= (count_nxt != FULL_CNT);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

module hex_uart_tx #(
   parameter int BAUDRATE    = 115200,
   parameter int MASTERCLOCK = 50000000,
   parameter int DIV         = MASTERCLOCK / BAUDRATE,
   parameter int DATA_WIDTH  = 32,
   parameter int FIFO_DEPTH  = 4,
   parameter int STOP_BITS   = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] value,
   input  logic                  value_good,
   output logic                  ready,
   output logic                  tx,
   output logic                  busy,
   output logic                  overflow
);
   localparam int NIB = DATA_WIDTH / 4;
   localparam int NW  = $clog2(NIB + 1);
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIV - 1);
   localparam logic [3:0]    FRAME_BITS  = 4'(8 + STOP_BITS);

   typedef enum logic [2:0] {
      S_IDLE,
`ifdef HEX_UART_PREFIX_EN
      S_PREFIX,
`endif
      S_DIGIT,
      S_CR,
      S_LF
   } seq_state_t;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
   endfunction

   logic                  fifo_pop;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  fifo_empty;

   hex_uart_tx_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (value_good),
      .push_dat (value),
      .pop      (fifo_pop),
      .head_dat (fifo_head),
      .empty    (fifo_empty),
      .ready    (ready)
   );

   assign overflow = reset_n && value_good && !ready;

   // Character sequencer
   seq_state_t            seq_state;
   seq_state_t            seq_nxt;
   logic [DATA_WIDTH-1:0] sv;
   logic [DATA_WIDTH-1:0] sv_nxt;
   logic [NW-1:0]         nib;
   logic [NW-1:0]         nib_nxt;
   logic                  chr_vld;
   logic [7:0]            chr_dat;
   logic                  chr_acc;
   logic                  ser_rdy;
`ifdef HEX_UART_PREFIX_EN
   logic                  px_second;
   logic                  px_nxt;
`endif

   assign chr_acc = chr_vld && ser_rdy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seq_state <= S_IDLE;
         sv        <= '0;
         nib       <= '0;
`ifdef HEX_UART_PREFIX_EN
         px_second <= 1'b0;
`endif
      end else begin
         seq_state <= seq_nxt;
         sv        <= sv_nxt;
         nib       <= nib_nxt;
`ifdef HEX_UART_PREFIX_EN
         px_second <= px_nxt;
`endif
      end
   end

   always_comb begin
      seq_nxt  = seq_state;
      sv_nxt   = sv;
      nib_nxt  = nib;
      fifo_pop = 1'b0;
      chr_vld  = 1'b0;
      chr_dat  = 8'h00;
`ifdef HEX_UART_PREFIX_EN
      px_nxt   = px_second;
`endif
      case (seq_state)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               sv_nxt   = fifo_head;
               nib_nxt  = NW'(NIB);
`ifdef HEX_UART_PREFIX_EN
               px_nxt   = 1'b0;
               seq_nxt  = S_PREFIX;
`else
               seq_nxt  = S_DIGIT;
`endif
            end
         end
`ifdef HEX_UART_PREFIX_EN
         S_PREFIX: begin
            chr_vld = 1'b1;
            chr_dat = px_second ? 8'h78 : 8'h30;
            if (chr_acc) begin
               px_nxt = !px_second;
               if (px_second) seq_nxt = S_DIGIT;
            end
         end
`endif
         S_DIGIT: begin
            chr_vld = 1'b1;
            chr_dat = hex_char(sv[DATA_WIDTH-1 -: 4]);
            if (chr_acc) begin
               sv_nxt  = sv << 4;
               nib_nxt = nib - 1'b1;
               if (nib == NW'(1)) seq_nxt = S_CR;
            end
         end
         S_CR: begin
            chr_vld = 1'b1;
            chr_dat = 8'h0D;
            if (chr_acc) seq_nxt = S_LF;
         end
         S_LF: begin
            chr_vld = 1'b1;
            chr_dat = 8'h0A;
            if (chr_acc) seq_nxt = S_IDLE;
         end
         default: seq_nxt = S_IDLE;
      endcase
   end

   // Serializer. A new byte loads on the last cycle of the previous stop bit, so frames are back-to-back.
   logic                 ser_act;
   logic [7+STOP_BITS:0] sh;
   logic [3:0]           bits_left;
   logic [CW-1:0]        baud_cnt;
   logic                 frame_end;

   assign frame_end = ser_act && (baud_cnt == '0) && (bits_left == 4'd0);
   assign ser_rdy   = !ser_act || frame_end;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ser_act   <= 1'b0;
         sh        <= '0;
         bits_left <= 4'd0;
         baud_cnt  <= BAUD_RELOAD;
         tx        <= 1'b1;
      end else if (chr_acc) begin
         ser_act   <= 1'b1;
         tx        <= 1'b0;
         sh        <= {{STOP_BITS{1'b1}}, chr_dat};
         bits_left <= FRAME_BITS;
         baud_cnt  <= BAUD_RELOAD;
      end else if (ser_act) begin
         if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
         end else if (bits_left == 4'd0) begin
            ser_act  <= 1'b0;
            tx       <= 1'b1;
            baud_cnt <= BAUD_RELOAD;
         end else begin
            tx        <= sh[0];
            sh        <= sh >> 1;
            bits_left <= bits_left - 1'b1;
            baud_cnt  <= BAUD_RELOAD;
         end
      end
   end

   assign busy = !fifo_empty || (seq_state != S_IDLE) || ser_act;
endmodule

// File: tb/tb_hex_uart_tx.sv
// Bench for hex_uart_tx: three configurations, a UART receiver sampling mid-bit and a queue of expected characters.
module tb_hex_uart_tx;
`ifdef HEX_UART_PREFIX_EN
   localparam int PFX = 2;
`else
   localparam int PFX = 0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] val_a, val_c;
   logic [7:0]  val_b;
   logic        vg_a, vg_b, vg_c;
   logic        rdy_a, rdy_b, rdy_c;
   logic        tx_a, tx_b, tx_c;
   logic        busy_a, busy_b, busy_c;
   logic        ovf_a, ovf_b, ovf_c;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   hex_uart_tx #(.DIV(8), .DATA_WIDTH(32), .FIFO_DEPTH(4), .STOP_BITS(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .value(val_a), .value_good(vg_a),
      .ready(rdy_a), .tx(tx_a), .busy(busy_a), .overflow(ovf_a));
   hex_uart_tx #(.DIV(8), .DATA_WIDTH(8), .FIFO_DEPTH(4), .STOP_BITS(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .value(val_b), .value_good(vg_b),
      .ready(rdy_b), .tx(tx_b), .busy(busy_b), .overflow(ovf_b));
   hex_uart_tx #(.DIV(4), .DATA_WIDTH(32), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_c (
      .clk(clk), .reset_n(reset_n), .value(val_c), .value_good(vg_c),
      .ready(rdy_c), .tx(tx_c), .busy(busy_c), .overflow(ovf_c));

   function automatic logic txs(input int d);
      case (d)
         0:       return tx_a;
         1:       return tx_b;
         default: return tx_c;
      endcase
   endfunction

   task automatic push_expect(input logic [63:0] v, input int ndig);
      string hexs = "0123456789ABCDEF";
`ifdef HEX_UART_PREFIX_EN
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h78);
`endif
      for (int i = ndig - 1; i >= 0; i--) exp_q.push_back(hexs[v[i*4 +: 4]]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   // Receives one frame starting from a negedge; it returns at the cycle after the frame ends.
   task automatic rx_byte(input int d, input int div, input int sb,
                          output logic [7:0] b, output int ts, output bit ok);
      int n;
      n  = 0;
      ok = 1'b1;
      b  = 8'h00;
      while (txs(d) !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      ts = cyc;
      if (n >= 2000) begin
         ok = 1'b0;
         return;
      end
      repeat (div / 2) @(negedge clk);
      if (txs(d) !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (div) @(negedge clk);
         b[i] = txs(d);
      end
      for (int s = 0; s < sb; s++) begin
         repeat (div) @(negedge clk);
         if (txs(d) !== 1'b1) ok = 1'b0;
      end
      repeat (div - div / 2) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      vg_a = 1'b0; vg_b = 1'b0; vg_c = 1'b0;
      val_a = '0; val_b = '0; val_c = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({tx_a, tx_b, tx_c} !== 3'b111) begin
         $display("FAIL reset_tx: got %b, expected 111", {tx_a, tx_b, tx_c}); n_errors++;
      end
      n_checks++;
      if ({rdy_a, rdy_b, rdy_c, busy_a, busy_b, busy_c, ovf_a, ovf_b, ovf_c} !== 9'b0) begin
         $display("FAIL reset_flags: ready/busy/overflow got %b, expected all 0",
                  {rdy_a, rdy_b, rdy_c, busy_a, busy_b, busy_c, ovf_a, ovf_b, ovf_c}); n_errors++;
      end
      reset_n = 1'b1;
      #1;
      n_checks++;
      if ({rdy_a, rdy_b, rdy_c} !== 3'b000) begin
         $display("FAIL ready_before_edge: got %b, expected 000", {rdy_a, rdy_b, rdy_c}); n_errors++;
      end
      @(negedge clk);
      n_checks++;
      if ({rdy_a, rdy_b, rdy_c} !== 3'b111) begin
         $display("FAIL ready_after_edge: got %b, expected 111", {rdy_a, rdy_b, rdy_c}); n_errors++;
      end
   endtask

   task automatic test_basic(input logic [31:0] v, input string nm);
      logic [7:0] b, e;
      int ts, tprev, tpush, nf;
      bit ok;
      for (int i = 0; i < 2000 && busy_a; i++) @(negedge clk);
      push_expect({32'h0, v}, 8);
      nf = exp_q.size();
      vg_a = 1'b1; val_a = v;
      @(posedge clk); @(negedge clk);
      vg_a = 1'b0;
      tpush = cyc;
      tprev = 0;
      for (int f = 0; f < nf; f++) begin
         rx_byte(0, 8, 1, b, ts, ok);
         e = exp_q.pop_front();
         n_checks++;
         if (!ok || b !== e) begin
            $display("FAIL %s_char[%0d]: got %h (framing ok=%0d), expected %h", nm, f, b, ok, e); n_errors++;
         end
         n_checks++;
         if (f == 0) begin
            if (ts - tpush > 2 || ts - tpush < 0) begin
               $display("FAIL %s_latency: got %0d cycles, expected <= 2", nm, ts - tpush); n_errors++;
            end
         end else if (ts - tprev != 80) begin
            $display("FAIL %s_spacing[%0d]: got %0d cycles, expected 80", nm, f, ts - tprev); n_errors++;
         end
         tprev = ts;
      end
   endtask

   task automatic test_leading_zero();
      logic [7:0] b, e;
      int ts, tprev, nf;
      bit ok;
      push_expect(64'h0F, 2);
      nf = exp_q.size();
      vg_b = 1'b1; val_b = 8'h0F;
      @(posedge clk); @(negedge clk);
      vg_b = 1'b0;
      tprev = 0;
      for (int f = 0; f < nf; f++) begin
         rx_byte(1, 8, 1, b, ts, ok);
         e = exp_q.pop_front();
         n_checks++;
         if (!ok || b !== e) begin
            $display("FAIL lz_char[%0d]: got %h (framing ok=%0d), expected %h", f, b, ok, e); n_errors++;
         end
         if (f > 0) begin
            n_checks++;
            if (ts - tprev != 80) begin
               $display("FAIL lz_spacing[%0d]: got %0d, expected 80", f, ts - tprev); n_errors++;
            end
         end
         tprev = ts;
      end
      n_checks++;
      if (busy_b !== 1'b0) begin
         $display("FAIL lz_busy_end: got %b, expected 0", busy_b); n_errors++;
      end
   endtask

   task automatic test_overflow();
      logic [31:0] w [6];
      logic [7:0] b, e;
      int ts, tprev, nf;
      bit ok;
      w = '{32'h00000001, 32'h89ABCDEF, 32'h76543210, 32'hFEDCBA98, 32'h13579BDF, 32'h2468ACE0};
      for (int i = 0; i < 2000 && busy_a; i++) @(negedge clk);
      nf = 5 * (10 + PFX);
      tprev = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               vg_a = 1'b1; val_a = w[i];
               #1;
               n_checks++;
               if (rdy_a !== (i < 5) || ovf_a !== (i == 5)) begin
                  $display("FAIL ovf_push[%0d]: ready=%b overflow=%b, expected ready=%b overflow=%b",
                           i, rdy_a, ovf_a, (i < 5), (i == 5)); n_errors++;
               end
               if (i < 5) push_expect({32'h0, w[i]}, 8);
               @(posedge clk); @(negedge clk);
            end
            vg_a = 1'b0;
         end
         begin
            for (int f = 0; f < nf; f++) begin
               rx_byte(0, 8, 1, b, ts, ok);
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
               n_checks++;
               if (!ok || b !== e) begin
                  $display("FAIL ovf_char[%0d]: got %h (framing ok=%0d), expected %h", f, b, ok, e); n_errors++;
               end
               if (f > 0) begin
                  n_checks++;
                  if (ts - tprev != 80) begin
                     $display("FAIL ovf_spacing[%0d]: got %0d, expected 80", f, ts - tprev); n_errors++;
                  end
               end
               tprev = ts;
            end
         end
      join
      n_checks++;
      if (busy_a !== 1'b0 || exp_q.size() != 0) begin
         $display("FAIL ovf_drain: busy=%b leftover=%0d, expected busy=0 leftover=0", busy_a, exp_q.size()); n_errors++;
      end
   endtask

   task automatic test_two_stop();
      logic [7:0] b, e;
      int ts, tprev, nf;
      bit ok;
      push_expect(64'hFFFFFFFF, 8);
      nf = exp_q.size();
      vg_c = 1'b1; val_c = 32'hFFFFFFFF;
      @(posedge clk); @(negedge clk);
      vg_c = 1'b0;
      tprev = 0;
      for (int f = 0; f < nf; f++) begin
         rx_byte(2, 4, 2, b, ts, ok);
         e = exp_q.pop_front();
         n_checks++;
         if (!ok || b !== e) begin
            $display("FAIL stop2_char[%0d]: got %h (framing ok=%0d), expected %h", f, b, ok, e); n_errors++;
         end
         if (f > 0) begin
            n_checks++;
            if (ts - tprev != 44) begin
               $display("FAIL stop2_spacing[%0d]: got %0d, expected 44", f, ts - tprev); n_errors++;
            end
         end
         tprev = ts;
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b, e;
      int ts;
      bit ok, low_seen;
      for (int i = 0; i < 2000 && busy_a; i++) @(negedge clk);
      push_expect(64'h12345678, 8);
      vg_a = 1'b1; val_a = 32'h12345678;
      @(posedge clk); @(negedge clk);
      val_a = 32'h9ABCDEF0;
      @(posedge clk); @(negedge clk);
      val_a = 32'h0BADF00D;
      @(posedge clk); @(negedge clk);
      vg_a = 1'b0;
      for (int f = 0; f < 2; f++) begin
         rx_byte(0, 8, 1, b, ts, ok);
         e = exp_q.pop_front();
         n_checks++;
         if (!ok || b !== e) begin
            $display("FAIL mid_char[%0d]: got %h (framing ok=%0d), expected %h", f, b, ok, e); n_errors++;
         end
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (tx_a !== 1'b1) begin
         $display("FAIL mid_reset_tx: got %b, expected 1", tx_a); n_errors++;
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      n_checks++;
      if (rdy_a !== 1'b0 || busy_a !== 1'b0) begin
         $display("FAIL mid_reset_flags: ready=%b busy=%b, expected 0 0", rdy_a, busy_a); n_errors++;
      end
      reset_n = 1'b1;
      low_seen = 1'b0;
      repeat (1500) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || busy_a !== 1'b0) low_seen = 1'b1;
      end
      n_checks++;
      if (low_seen || rdy_a !== 1'b1) begin
         $display("FAIL mid_quiet: activity=%b ready=%b, expected activity=0 ready=1", low_seen, rdy_a); n_errors++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic(32'h1234ABCD, "basic");
      test_leading_zero();
      test_overflow();
      test_two_stop();
      test_reset_mid();
      test_basic(32'h00000000, "zeros");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
